// File: rtl/m_wbuart_pkg.sv
// Shared register offsets, status/control bit positions and FSM encodings
// for the Wishbone UART.
package m_wbuart_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DIV    = 2'd2;
  localparam logic [1:0] ADR_CTRL   = 2'd3;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXFULL = 1;
  localparam int ST_TXIDLE = 2;
  localparam int ST_RXOVR  = 3;
  localparam int ST_FERR   = 4;
  localparam int ST_TXOVF  = 5;

  localparam int CT_LOOP = 0;
  localparam int CT_RXIE = 1;
  localparam int CT_TXIE = 2;

  // Shared by the TX and RX state machines
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/m_wbuart_fifo.sv
// Small register-based FIFO with combinational head output; a push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module m_wbuart_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTHLOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTHLOG2;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTHLOG2-1:0] wr_ptr;
  logic [DEPTHLOG2-1:0] rd_ptr;
  logic [DEPTHLOG2:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTHLOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/m_wbuart.sv
// Wishbone-classic UART: programmable divisor, RX/TX FIFOs, sticky error
// flags, internal loopback and a single registered level interrupt.
module m_wbuart
  import m_wbuart_pkg::*;
#(
  parameter int DATABITS    = 8,
  parameter int RXDEPTHLOG2 = 4,
  parameter int TXDEPTHLOG2 = 2,
  parameter int DIVWIDTH    = 16,
  parameter int DEFDIV      = 103
) (
  input  logic        CLK_I,
  input  logic        RSTn_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [1:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        irq
);

  localparam int BW = $clog2(DATABITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATABITS - 1);

  logic                wr, rd;
  logic [DIVWIDTH-1:0] divisor;
  logic [DIVWIDTH-1:0] half_div;
  logic [2:0]          ctrl;
  logic                rx_ovr, ferr, tx_ovf;
  logic [31:0]         status;
  logic                unused_dat;

  logic                tx_push, tx_pop, tx_empty, tx_full, tx_idle, tx_line;
  logic [DATABITS-1:0] tx_dout, tx_shift;
  logic [1:0]          tx_state;
  logic [DIVWIDTH-1:0] tx_cnt;
  logic [BW-1:0]       tx_bit;

  logic                rx_in, sync_1, sync_2, rx_push, rx_pop, rx_empty, rx_full;
  logic                rx_stop_end;
  logic [DATABITS-1:0] rx_dout, rx_shift;
  logic [1:0]          rx_state;
  logic [DIVWIDTH-1:0] rx_cnt;
  logic [BW-1:0]       rx_bit;

  assign ACK_O      = CYC_I & STB_I;
  assign wr         = ACK_O & WE_I;
  assign rd         = ACK_O & ~WE_I;
  assign unused_dat = ^DAT_I;
  assign half_div   = DIVWIDTH'(({1'b0, divisor} + (DIVWIDTH+1)'(1)) >> 1);

  assign tx_push = wr & (ADR_I == ADR_DATA);
  assign tx_pop  = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_cnt == '0)));
  assign tx_idle = tx_empty & (tx_state == S_IDLE);
  assign usartTX = ctrl[CT_LOOP] | tx_line;

  assign rx_in       = ctrl[CT_LOOP] ? tx_line : usartRX;
  assign rx_stop_end = (rx_state == S_STOP) & (rx_cnt == '0);
  assign rx_push     = rx_stop_end & sync_2;
  assign rx_pop      = rd & (ADR_I == ADR_DATA) & ~rx_empty;

  m_wbuart_fifo #(.WIDTH(DATABITS), .DEPTHLOG2(TXDEPTHLOG2)) u_tx_fifo (
    .clk(CLK_I), .rst_n(RSTn_I), .push(tx_push), .pop(tx_pop),
    .din(DAT_I[DATABITS-1:0]), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  m_wbuart_fifo #(.WIDTH(DATABITS), .DEPTHLOG2(RXDEPTHLOG2)) u_rx_fifo (
    .clk(CLK_I), .rst_n(RSTn_I), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // STOP with a waiting word goes straight to START, so frames run back to back
  always_ff @(posedge CLK_I or negedge RSTn_I) begin
    if (!RSTn_I) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE, S_STOP: begin
          if (tx_state == S_STOP && tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else if (tx_pop) begin
            tx_shift <= tx_dout;
            tx_line  <= 1'b0;
            tx_cnt   <= divisor;
            tx_state <= S_START;
          end else begin
            tx_state <= S_IDLE;
          end
        end
        S_START: begin
          if (tx_cnt == '0) begin
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATABITS-1:1]};
            tx_bit   <= '0;
            tx_cnt   <= divisor;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: begin
          if (tx_cnt == '0) begin
            tx_cnt <= divisor;
            if (tx_bit == LAST_BIT) begin
              tx_line  <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATABITS-1:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Start is detected on sync_1 so the half-bit count lands mid-bit on sync_2
  always_ff @(posedge CLK_I or negedge RSTn_I) begin
    if (!RSTn_I) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      sync_1 <= rx_in;
      sync_2 <= sync_1;
      case (rx_state)
        S_IDLE: begin
          if (sync_2 && !sync_1) begin
            rx_cnt   <= half_div;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (sync_2) begin
            rx_state <= S_IDLE;
          end else begin
            rx_cnt   <= divisor;
            rx_bit   <= '0;
            rx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {sync_2, rx_shift[DATABITS-1:1]};
            rx_cnt   <= divisor;
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == LAST_BIT) rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: begin
          if (rx_cnt == '0) rx_state <= S_IDLE;
          else              rx_cnt   <= rx_cnt - 1'b1;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge CLK_I or negedge RSTn_I) begin
    if (!RSTn_I) begin
      divisor <= DIVWIDTH'(DEFDIV);
      ctrl    <= '0;
      rx_ovr  <= 1'b0;
      ferr    <= 1'b0;
      tx_ovf  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr && ADR_I == ADR_DIV)  divisor <= DIVWIDTH'(DAT_I);
      if (wr && ADR_I == ADR_CTRL) ctrl    <= DAT_I[2:0];
      rx_ovr <= (rx_push & rx_full & ~rx_pop) |
                (rx_ovr & ~(wr & (ADR_I == ADR_STATUS) & DAT_I[ST_RXOVR]));
      ferr   <= (rx_stop_end & ~sync_2) |
                (ferr & ~(wr & (ADR_I == ADR_STATUS) & DAT_I[ST_FERR]));
      tx_ovf <= (tx_push & tx_full & ~tx_pop) |
                (tx_ovf & ~(wr & (ADR_I == ADR_STATUS) & DAT_I[ST_TXOVF]));
      irq    <= (ctrl[CT_RXIE] & ~rx_empty) | (ctrl[CT_TXIE] & tx_idle);
    end
  end

  always_comb begin
    status            = '0;
    status[ST_RXNE]   = ~rx_empty;
    status[ST_TXFULL] = tx_full;
    status[ST_TXIDLE] = tx_idle;
    status[ST_RXOVR]  = rx_ovr;
    status[ST_FERR]   = ferr;
    status[ST_TXOVF]  = tx_ovf;
  end

  always_comb begin
    DAT_O = '0;
    case (ADR_I)
      ADR_DATA:   if (!rx_empty) DAT_O = 32'(rx_dout);
      ADR_STATUS: DAT_O = status;
      ADR_DIV:    DAT_O = 32'(divisor);
      default:    DAT_O = 32'(ctrl);
    endcase
  end

endmodule

// File: tb/tb_m_wbuart.sv
// Directed-plus-random bench for m_wbuart; expected frames, FIFO contents and
// flags come from a queue-based model of the UART's documented behaviour.
module tb_m_wbuart;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        usart_rx = 1'b1;
  logic        usart_tx;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rx_q[$];
  logic [31:0] rdata;
  logic [7:0]  b;
  bit          exp_ovr;
  bit          saw_low;
  int          n, rxne_cyc, irq_cyc;

  m_wbuart dut (
    .CLK_I(clk), .RSTn_I(rst_n), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat_i), .DAT_O(dat_o), .ACK_O(ack),
    .usartRX(usart_rx), .usartTX(usart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    #1 d = dat_o;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
  endtask

  function automatic logic [31:0] st(bit rxne, bit txfull, bit txidle, bit rxovr, bit fe, bit txovf);
    return {26'd0, txovf, fe, rxovr, txidle, txfull, rxne};
  endfunction

  // Expected line at each clock = frame bit (clock index / bit period)
  task automatic tx_wave(input string tag, input logic [7:0] d, input int per);
    logic [9:0] frame;
    int wait_n;
    frame = {1'b1, d, 1'b0};
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (usart_tx !== 1'b0 && wait_n < 20);
    check({tag, "_latency"}, 32'(wait_n), 32'd2);
    for (int i = 0; i < 10 * per; i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, i / per), {31'd0, usart_tx}, {31'd0, frame[i / per]});
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int per);
    usart_rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      usart_rx = d[i];
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int per);
    send_bits(d, per);
    usart_rx = stop;
    repeat (per) @(negedge clk);
    usart_rx = 1'b1;
    repeat (per) @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_usart_tx", {31'd0, usart_tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    wb_read(2'd1, rdata); check("rst_status", rdata, st(0, 0, 1, 0, 0, 0));
    wb_read(2'd2, rdata); check("rst_div", rdata, 32'd103);
    wb_read(2'd3, rdata); check("rst_ctrl", rdata, 32'd0);
    wb_read(2'd0, rdata); check("rst_data", rdata, 32'd0);

    // TX waveform at DIV=3
    wb_write(2'd2, 32'd3);
    wb_read(2'd2, rdata); check("div_rd", rdata, 32'd3);
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'hA5 : 8'($urandom);
      wb_write(2'd0, {24'd0, b});
      $display("[TB] tx frame %0d data=0x%02h", f, b);
      tx_wave($sformatf("tx%0d", f), b, 4);
      wb_read(2'd1, rdata); check("tx_idle_after", rdata, st(0, 0, 1, 0, 0, 0));
    end

    // Loopback at DIV=3
    wb_write(2'd3, 32'd1);
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h3C : (k == 1) ? 8'hC3 : 8'($urandom);
      wb_write(2'd0, {24'd0, b});
      rx_q.push_back(b);
    end
    saw_low = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (usart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("loop_tx_held", {31'd0, saw_low}, 32'd0);
    wb_read(2'd1, rdata); check("loop_status", rdata, st(1, 0, 1, 0, 0, 0));
    while (rx_q.size() > 0) begin
      wb_read(2'd0, rdata);
      $display("[TB] loop read 0x%02h", rdata[7:0]);
      check("loop_data", rdata, {24'd0, rx_q.pop_front()});
    end
    wb_read(2'd0, rdata); check("loop_empty_data", rdata, 32'd0);
    wb_read(2'd1, rdata); check("loop_empty_status", rdata, st(0, 0, 1, 0, 0, 0));

    // Loopback at DIV=0 (one clock per bit)
    wb_write(2'd2, 32'd0);
    b = 8'($urandom);
    wb_write(2'd0, {24'd0, b});
    repeat (30) @(negedge clk);
    wb_read(2'd1, rdata); check("div0_status", rdata, st(1, 0, 1, 0, 0, 0));
    wb_read(2'd0, rdata); check("div0_data", rdata, {24'd0, b});
    wb_write(2'd3, 32'd0);
    wb_write(2'd2, 32'd3);

    // TX overflow: 4 FIFO slots plus the shifter take 5 words
    for (int k = 1; k <= 6; k++) begin
      wb_write(2'd0, 32'($urandom_range(0, 255)));
      wb_read(2'd1, rdata);
      $display("[TB] tx burst write %0d status=0x%02h", k, rdata[7:0]);
      check($sformatf("txovf_w%0d", k), rdata, st(0, k >= 5, 0, 0, 0, k >= 6));
    end
    wb_write(2'd1, 32'h20);
    wb_read(2'd1, rdata); check("txovf_clear", rdata, st(0, 1, 0, 0, 0, 0));
    repeat (250) @(negedge clk);
    wb_read(2'd1, rdata); check("tx_drained", rdata, st(0, 0, 1, 0, 0, 0));

    // Framing error, then clear it
    send_frame(8'($urandom), 1'b0, 4);
    repeat (8) @(negedge clk);
    wb_read(2'd1, rdata); check("ferr_status", rdata, st(0, 0, 1, 0, 1, 0));
    wb_write(2'd1, 32'h10);
    wb_read(2'd1, rdata); check("ferr_clear", rdata, st(0, 0, 1, 0, 0, 0));

    // One-clock glitch must not start a frame
    @(negedge clk); usart_rx = 1'b0;
    @(negedge clk); usart_rx = 1'b1;
    repeat (40) @(negedge clk);
    wb_read(2'd1, rdata); check("glitch_status", rdata, st(0, 0, 1, 0, 0, 0));

    // 17 frames into a 16-deep RX FIFO
    exp_ovr = 1'b0;
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 4);
      if (rx_q.size() < 16) rx_q.push_back(b);
      else exp_ovr = 1'b1;
    end
    repeat (10) @(negedge clk);
    wb_read(2'd1, rdata); check("rxovr_status", rdata, st(1, 0, 1, exp_ovr, 0, 0));
    while (rx_q.size() > 0) begin
      wb_read(2'd0, rdata);
      $display("[TB] rx read 0x%02h", rdata[7:0]);
      check("rx_data", rdata, {24'd0, rx_q.pop_front()});
    end
    wb_read(2'd0, rdata); check("rx_empty_data", rdata, 32'd0);
    wb_write(2'd1, 32'h08);
    wb_read(2'd1, rdata); check("rxovr_clear", rdata, st(0, 0, 1, 0, 0, 0));

    // RX interrupt latency: irq follows RXNE by one clock
    wb_write(2'd3, 32'd2);
    @(negedge clk);
    check("irq_idle", {31'd0, irq}, 32'd0);
    b = 8'($urandom);
    send_bits(b, 4);
    usart_rx = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
    rxne_cyc = -1; irq_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dat_o[0] === 1'b1 && rxne_cyc < 0) rxne_cyc = c;
      if (irq === 1'b1 && irq_cyc < 0) irq_cyc = c;
    end
    cyc = 1'b0; stb = 1'b0;
    check("irq_rxne_seen", {31'd0, rxne_cyc >= 0}, 32'd1);
    check("irq_latency", 32'(irq_cyc), 32'(rxne_cyc + 1));
    wb_read(2'd0, rdata); check("irq_data", rdata, {24'd0, b});
    repeat (2) @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    wb_write(2'd3, 32'd4);
    repeat (2) @(negedge clk);
    check("irq_txie", {31'd0, irq}, 32'd1);
    wb_write(2'd3, 32'd0);

    // Asynchronous reset in the middle of a TX frame
    wb_write(2'd2, 32'd7);
    wb_write(2'd0, 32'h55);
    wb_write(2'd0, 32'hAA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (usart_tx !== 1'b0 && n < 20);
    check("mid_tx_started", {31'd0, usart_tx}, 32'd0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_tx_reset_line", {31'd0, usart_tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read(2'd1, rdata); check("mid_tx_status", rdata, st(0, 0, 1, 0, 0, 0));
    wb_read(2'd2, rdata); check("mid_tx_div", rdata, 32'd103);
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (usart_tx !== 1'b1) saw_low = 1'b1;
    end
    check("mid_tx_no_resume", {31'd0, saw_low}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
